// File: rtl/mips16_alu_pkg.sv
// rtl/mips16_alu_pkg.sv - shared MIPS-16 ALU defaults and flag type
package mips16_alu_pkg;

    localparam int DEF_ADD_WIDTH  = 16;
    localparam int DEF_ADD_STAGES = 2;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational SLICE-bit ripple adder built from half-adder pairs
// Ports: a, b, cin -> s (SLICE bits), cout (carry out of the slice MSB),
//        c_msb (carry into the slice MSB, needed for signed overflow)
module adder_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] c;

    always_comb begin
        logic h_s;
        logic h_c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            // first half adder: operand bits; second: partial sum plus carry
            h_s      = a[i] ^ b[i];
            h_c      = a[i] & b[i];
            s[i]     = h_s ^ c[i];
            c[i + 1] = h_c | (h_s & c[i]);
        end
    end

    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined carry-chain adder, one SLICE-bit slice per stage
// Optional feature macro: PIPE_ADDER_SUB_EN adds input sub (a + ~b + 1, cin ignored).
// Ports: clk, rst_n (async, active low)
//        in_valid/in_ready, a, b, cin [, sub]  - operand side
//        out_valid/out_ready, sum, cout, ovf, zero - result side
module pipe_adder
    import mips16_alu_pkg::*;
#(
    parameter int WIDTH  = DEF_ADD_WIDTH,
    parameter int STAGES = DEF_ADD_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $fatal(1, "pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    logic              init_q;
    logic              accept;
    alu_flags_t        flags;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Advance chain runs from the output back to stage 0 so a full pipe can
    // shift in the same cycle the consumer takes a result.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = valid_q[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
        end
    end

    // init_q keeps in_ready low until the first edge after reset release.
    assign in_ready = init_q & (~valid_q[0] | adv[0]);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            init_q  <= 1'b0;
        end else begin
            init_q     <= 1'b1;
            valid_q[0] <= accept | (valid_q[0] & ~adv[0]);
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= adv[k-1] | (valid_q[k] & ~adv[k]);
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SLICE;
        localparam int HI = LO + SLICE;

        logic [WIDTH-LO-1:0] op_a;      // operand bits not yet added, bit 0 = bit LO
        logic [WIDTH-LO-1:0] op_b;
        logic                c_in;
        logic                load;
        logic [SLICE-1:0]    s_sl;
        logic                c_out;
        logic                c_msb;
        logic [HI-1:0]       psum_d;
        logic [HI-1:0]       psum_q;
        logic                carry_q;
        logic                cmsb_q;

        if (k == 0) begin : g_head
            assign op_a   = a;
            assign op_b   = b_eff;
            assign c_in   = cin_eff;
            assign load   = accept;
            assign psum_d = s_sl;
        end else begin : g_body
            assign op_a   = g_stage[k-1].g_rem.rem_a_q;
            assign op_b   = g_stage[k-1].g_rem.rem_b_q;
            assign c_in   = g_stage[k-1].carry_q;
            assign load   = adv[k-1];
            assign psum_d = {s_sl, g_stage[k-1].psum_q};
        end

        adder_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a     (op_a[SLICE-1:0]),
            .b     (op_b[SLICE-1:0]),
            .cin   (c_in),
            .s     (s_sl),
            .cout  (c_out),
            .c_msb (c_msb)
        );

        // Registers only load on a transfer, so idle stages keep their last
        // (known) contents and never push undriven input bits downstream.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                psum_q  <= '0;
                carry_q <= 1'b0;
                cmsb_q  <= 1'b0;
            end else if (load) begin
                psum_q  <= psum_d;
                carry_q <= c_out;
                cmsb_q  <= c_msb;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [WIDTH-HI-1:0] rem_a_q;
            logic [WIDTH-HI-1:0] rem_b_q;
            // carry into a slice MSB only matters once that MSB is the word MSB
            logic                unused_cmsb;

            assign unused_cmsb = cmsb_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a_q <= '0;
                    rem_b_q <= '0;
                end else if (load) begin
                    rem_a_q <= op_a[WIDTH-LO-1:SLICE];
                    rem_b_q <= op_b[WIDTH-LO-1:SLICE];
                end
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign sum        = g_stage[STAGES-1].psum_q;
    assign flags.cout = g_stage[STAGES-1].carry_q;
    assign flags.ovf  = g_stage[STAGES-1].cmsb_q ^ g_stage[STAGES-1].carry_q;
    // gated so the reset/idle state reports zero=0 rather than "sum is 0"
    assign flags.zero = valid_q[STAGES-1] & ~|g_stage[STAGES-1].psum_q;

    assign cout = flags.cout;
    assign ovf  = flags.ovf;
    assign zero = flags.zero;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder
module tb_pipe_adder;

    localparam int W = 16;
    localparam int S = 2;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         op_sub    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    res_t exp_next;
    res_t e;
    res_t held;
    res_t sb[$];
    int   out_cycles[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   out_count = 0;
    int   base;
    int   acc;
    logic took;
    logic stall_prev = 1'b0;

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   full;
        res_t         r;
        yy     = s ? ~y : y;
        cc     = s ? 1'b1 : c;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (r.sum[W-1] != x[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // scoreboard: push on input transfer, pop/compare on output transfer
    always @(negedge clk) begin
        if (rst_n && stall_prev && out_valid) begin
            chk("hold_sum", 32'(sum), 32'(held.sum));
            chk("hold_flags", {29'd0, cout, ovf, zero}, {29'd0, held.cout, held.ovf, held.zero});
        end
        stall_prev = rst_n & out_valid & ~out_ready;
        held       = {sum, cout, ovf, zero};
        if (rst_n && out_valid && out_ready) begin
            out_count++;
            out_cycles.push_back(cyc);
            n_checks++;
            assert (sb.size() > 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL unexpected_output observed=%h expected=none", sum);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("zero", 32'(zero), 32'(e.zero));
            end
        end
        if (rst_n && in_valid && in_ready) sb.push_back(exp_next);
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input res_t ex);
        int n;
        n        = 0;
        a        = x;
        b        = y;
        cin      = c;
        op_sub   = s;
        exp_next = ex;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic s);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        x = W'($urandom);
        y = W'($urandom);
        c = 1'($urandom_range(0, 1));
        send(x, y, c, s, model(x, y, c, s));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // signed overflow plus latency
        out_ready = 1'b1;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
        for (int i = 1; i < S; i++) begin
            @(negedge clk);
            chk("lat_early", 32'(out_valid), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        drain();

        // wrap to zero and inter-stage carry
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 1'b0, 1'b0, 1'b0});
        drain();

        // back-to-back random stream
        base = out_count;
        for (int i = 0; i < 8; i++) send_rand(1'b0);
        drain();
        chk("stream_count", 32'(out_count - base), 32'd8);
        chk("stream_consecutive", 32'(out_cycles[$] - out_cycles[$-7]), 32'd7);

        // backpressure: consumer stalls for 5 cycles
        out_ready = 1'b0;
        acc       = 0;
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'b1;
        op_sub    = 1'b0;
        exp_next  = model(a, b, cin, 1'b0);
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk);
            #1;
            if (took) begin
                a        = W'($urandom);
                b        = W'($urandom);
                exp_next = model(a, b, cin, 1'b0);
            end
        end
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_accepted", 32'(acc), 32'(S));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // reset with operands in flight
        out_ready = 1'b0;
        for (int i = 0; i < S; i++) send_rand(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        sb.delete();
        base = out_count;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_count", 32'(out_count - base), 32'd0);
        chk("no_stale_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_ADDER_SUB_EN
        // subtract mode
        send(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0});
        send(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 6; i++) send_rand(1'($urandom_range(0, 1)));
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
